// File: rtl/lt24_frame_monitor.sv
// ---------------------------------------------------------------------------
// lt24_frame_monitor
//
// Passive monitor for an LT24 display bus. It snoops the write strobe and
// splits traffic into commands (RS=0) and pixel data (RS=1). It counts pixels
// in the current frame and reports each completed WIDTH*HEIGHT frame with a
// rotate-XOR checksum. A run stops after MAX_FRAMES frames (stop) or after
// MAX_CYCLES clocks (timeout). The monitor only has inputs from the bus and
// never drives it.
//
// Handshake: there is no valid/ready pair. A bus write is taken as one
// transaction on the rising edge of LT24Wr_n while LT24CS_n is low. RS and
// data are taken from the last clock on which LT24Wr_n was low. The effect
// shows on the outputs one clock later. frameDone and frameAbort are
// single-cycle pulses and cannot be held off.
//
// Ports
//   clock          in   1      system clock (shared with the monitored driver)
//   globalReset_n  in   1      asynchronous reset, active-low
//   LT24Wr_n       in   1      snooped write strobe
//   LT24CS_n       in   1      snooped chip select
//   LT24RS         in   1      snooped register select (0 command, 1 data)
//   LT24Reset_n    in   1      snooped display reset
//   LT24Data       in   16     snooped data bus
//   frameDone      out  1      pulse: full frame completed
//   frameAbort     out  1      pulse: partial frame abandoned
//   frameCount     out  8      completed frames, saturating at 255
//   pixelCount     out  17     pixels written in the current frame
//   lastChecksum   out  32     checksum of the most recent completed frame
//   cycleCount     out  CNT_W  clocks since reset release, saturating
//   stop           out  1      sticky: frame limit reached
//   timeout        out  1      sticky: cycle limit reached first
//   o_dbg_state    out  3      current FSM state, for observation only
// ---------------------------------------------------------------------------
module lt24_frame_monitor #(
  parameter int WIDTH      = 240,
  parameter int HEIGHT     = 320,
  parameter int MAX_FRAMES = 2,
  parameter int MAX_CYCLES = 10000000,
  parameter int CNT_W      = 32
) (
  input  logic             clock,
  input  logic             globalReset_n,
  input  logic             LT24Wr_n,
  input  logic             LT24CS_n,
  input  logic             LT24RS,
  input  logic             LT24Reset_n,
  input  logic [15:0]      LT24Data,
  output logic             frameDone,
  output logic             frameAbort,
  output logic [7:0]       frameCount,
  output logic [16:0]      pixelCount,
  output logic [31:0]      lastChecksum,
  output logic [CNT_W-1:0] cycleCount,
  output logic             stop,
  output logic             timeout,
  output logic [2:0]       o_dbg_state
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WAIT    = 3'd1;
  localparam logic [2:0] S_PIXELS  = 3'd2;
  localparam logic [2:0] S_DONE    = 3'd3;
  localparam logic [2:0] S_TIMEOUT = 3'd4;

  localparam logic [15:0]      CMD_RAMWR  = 16'h002C;
  localparam logic [15:0]      CMD_RAMCNT = 16'h003C;
  localparam logic [16:0]      LAST_PIX   = 17'(WIDTH * HEIGHT - 1);
  localparam logic [31:0]      MAXF       = 32'(MAX_FRAMES);
  localparam logic [CNT_W-1:0] MAXC       = CNT_W'(MAX_CYCLES);
  localparam logic [CNT_W-1:0] CYC_ONES   = {CNT_W{1'b1}};

  // Registered copies of the snooped bus.
  logic        r_wr_q;
  logic        r_rs_q;
  logic [15:0] r_data_q;

  // Monitor state.
  logic [2:0]       r_state;
  logic [16:0]      r_pix;
  logic [31:0]      r_chk;
  logic [7:0]       r_fcnt;
  logic [31:0]      r_last;
  logic [CNT_W-1:0] r_cyc;
  logic             r_stop;
  logic             r_timeout;
  logic             r_done;
  logic             r_abort;

  // Next-state values.
  logic [2:0]       w_state_n;
  logic [16:0]      w_pix_n;
  logic [31:0]      w_chk_n;
  logic [7:0]       w_fcnt_n;
  logic [31:0]      w_last_n;
  logic [CNT_W-1:0] w_cyc_n;
  logic             w_stop_n;
  logic             w_timeout_n;
  logic             w_done_n;
  logic             w_abort_n;

  // Decode helpers.
  logic             w_strobe;
  logic             w_cmd;
  logic             w_dat;
  logic             w_is_ramwr;
  logic             w_is_ramcnt;
  logic             w_terminal;
  logic             w_pix_nz;
  logic [31:0]      w_chk_upd;
  logic [7:0]       w_fcnt_inc;
  logic [CNT_W-1:0] w_cyc_inc;
  logic             w_cyc_hit;
  logic             w_frame_hit;

  // A write is taken on the rising edge of the write strobe. RS and data
  // were latched while the strobe was low, so the bus may already have
  // moved on by the time the edge is seen.
  assign w_strobe    = ~r_wr_q & LT24Wr_n & ~LT24CS_n;
  assign w_cmd       = w_strobe & ~r_rs_q;
  assign w_dat       = w_strobe &  r_rs_q;
  assign w_is_ramwr  = (r_data_q == CMD_RAMWR);
  assign w_is_ramcnt = (r_data_q == CMD_RAMCNT);

  assign w_terminal  = (r_state == S_DONE) || (r_state == S_TIMEOUT);
  assign w_pix_nz    = (r_pix != 17'd0);
  assign w_chk_upd   = {r_chk[30:0], r_chk[31]} ^ {16'h0000, r_data_q};
  assign w_fcnt_inc  = (r_fcnt == 8'hFF) ? r_fcnt : r_fcnt + 8'd1;
  assign w_cyc_inc   = (r_cyc == CYC_ONES) ? r_cyc : r_cyc + CNT_W'(1);

  // The frame limit is compared with the incremented count so that stop is
  // raised on the same clock as the last frameDone. A limit above 255 can
  // never match the 8-bit saturating count, so such a run never stops on
  // frames.
  assign w_frame_hit = (MAX_FRAMES != 0) && ({24'h000000, w_fcnt_inc} == MAXF);
  assign w_cyc_hit   = (MAX_CYCLES != 0) && (w_cyc_inc == MAXC);

  always_comb begin
    w_state_n   = r_state;
    w_pix_n     = r_pix;
    w_chk_n     = r_chk;
    w_fcnt_n    = r_fcnt;
    w_last_n    = r_last;
    w_cyc_n     = r_cyc;
    w_stop_n    = r_stop;
    w_timeout_n = r_timeout;
    w_done_n    = 1'b0;
    w_abort_n   = 1'b0;

    if (!w_terminal) begin
      w_cyc_n = w_cyc_inc;

      if (!LT24Reset_n) begin
        // The display was reset under us. Drop the partial frame but keep
        // the run statistics.
        w_state_n = S_IDLE;
        w_abort_n = w_pix_nz;
        w_pix_n   = 17'd0;
        w_chk_n   = 32'd0;
      end else begin
        case (r_state)
          S_IDLE: begin
            w_state_n = S_WAIT;
          end

          S_WAIT: begin
            if (w_cmd && w_is_ramwr) begin
              w_pix_n   = 17'd0;
              w_chk_n   = 32'd0;
              w_state_n = S_PIXELS;
            end
          end

          S_PIXELS: begin
            if (w_dat) begin
              if (r_pix == LAST_PIX) begin
                // Last pixel of the window. The driver may keep streaming,
                // so we wrap straight into the next frame.
                w_done_n = 1'b1;
                w_last_n = w_chk_upd;
                w_fcnt_n = w_fcnt_inc;
                w_pix_n  = 17'd0;
                w_chk_n  = 32'd0;
                if (w_frame_hit) begin
                  w_stop_n  = 1'b1;
                  w_state_n = S_DONE;
                end
              end else begin
                w_pix_n = r_pix + 17'd1;
                w_chk_n = w_chk_upd;
              end
            end else if (w_cmd && !w_is_ramcnt) begin
              // RAMWR restarts the frame in place. Any other command
              // leaves pixel mode. RAMCNT changes nothing.
              w_abort_n = w_pix_nz;
              w_pix_n   = 17'd0;
              w_chk_n   = 32'd0;
              if (!w_is_ramwr) begin
                w_state_n = S_WAIT;
              end
            end
          end

          default: begin
            w_state_n = r_state;
          end
        endcase
      end

      // If the frame limit and the cycle limit are reached on the same
      // clock, the frame limit wins.
      if (w_cyc_hit && !w_stop_n) begin
        w_timeout_n = 1'b1;
        w_state_n   = S_TIMEOUT;
      end
    end
  end

  always_ff @(posedge clock or negedge globalReset_n) begin
    if (!globalReset_n) begin
      r_wr_q   <= 1'b1;
      r_rs_q   <= 1'b0;
      r_data_q <= 16'h0000;
    end else begin
      r_wr_q <= LT24Wr_n;
      if (!LT24Wr_n) begin
        r_rs_q   <= LT24RS;
        r_data_q <= LT24Data;
      end
    end
  end

  always_ff @(posedge clock or negedge globalReset_n) begin
    if (!globalReset_n) begin
      r_state   <= S_IDLE;
      r_pix     <= 17'd0;
      r_chk     <= 32'd0;
      r_fcnt    <= 8'd0;
      r_last    <= 32'd0;
      r_cyc     <= '0;
      r_stop    <= 1'b0;
      r_timeout <= 1'b0;
      r_done    <= 1'b0;
      r_abort   <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_pix     <= w_pix_n;
      r_chk     <= w_chk_n;
      r_fcnt    <= w_fcnt_n;
      r_last    <= w_last_n;
      r_cyc     <= w_cyc_n;
      r_stop    <= w_stop_n;
      r_timeout <= w_timeout_n;
      r_done    <= w_done_n;
      r_abort   <= w_abort_n;
    end
  end

  assign frameDone    = r_done;
  assign frameAbort   = r_abort;
  assign frameCount   = r_fcnt;
  assign pixelCount   = r_pix;
  assign lastChecksum = r_last;
  assign cycleCount   = r_cyc;
  assign stop         = r_stop;
  assign timeout      = r_timeout;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_lt24_frame_monitor.sv
module tb_lt24_frame_monitor;

  localparam int NPIX = 8;   // 4 x 2 window
  localparam int MF   = 2;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic globalReset_n = 1'b0;
  always #5 clock = ~clock;

  logic [31:0] cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Main bus
  logic        LT24Wr_n = 1'b1, LT24CS_n = 1'b1, LT24RS = 1'b0, LT24Reset_n = 1'b0;
  logic [15:0] LT24Data = 16'h0;
  // Quiet bus for the cycle-limit instances
  logic        q_wr_n = 1'b1, q_cs_n = 1'b1, q_rs = 1'b0, q_rst_n = 1'b1;
  logic [15:0] q_data = 16'h0;

  logic        frameDone, frameAbort, stop, timeout;
  logic [7:0]  frameCount;
  logic [16:0] pixelCount;
  logic [31:0] lastChecksum, cycleCount;
  logic [2:0]  dbg_state;

  logic        to_done, to_abort, to_stop, to_timeout;
  logic [7:0]  to_fcnt;
  logic [16:0] to_pix;
  logic [31:0] to_last, to_cyc;
  logic [2:0]  to_state;

  logic        nt_done, nt_abort, nt_stop, nt_timeout;
  logic [7:0]  nt_fcnt;
  logic [16:0] nt_pix;
  logic [31:0] nt_last, nt_cyc;
  logic [2:0]  nt_state;

  lt24_frame_monitor #(.WIDTH(4), .HEIGHT(2), .MAX_FRAMES(2), .MAX_CYCLES(1000), .CNT_W(32)) u_main (
    .clock(clock), .globalReset_n(globalReset_n), .LT24Wr_n(LT24Wr_n), .LT24CS_n(LT24CS_n),
    .LT24RS(LT24RS), .LT24Reset_n(LT24Reset_n), .LT24Data(LT24Data),
    .frameDone(frameDone), .frameAbort(frameAbort), .frameCount(frameCount), .pixelCount(pixelCount),
    .lastChecksum(lastChecksum), .cycleCount(cycleCount), .stop(stop), .timeout(timeout),
    .o_dbg_state(dbg_state));

  lt24_frame_monitor #(.WIDTH(4), .HEIGHT(2), .MAX_FRAMES(2), .MAX_CYCLES(50), .CNT_W(32)) u_to (
    .clock(clock), .globalReset_n(globalReset_n), .LT24Wr_n(q_wr_n), .LT24CS_n(q_cs_n),
    .LT24RS(q_rs), .LT24Reset_n(q_rst_n), .LT24Data(q_data),
    .frameDone(to_done), .frameAbort(to_abort), .frameCount(to_fcnt), .pixelCount(to_pix),
    .lastChecksum(to_last), .cycleCount(to_cyc), .stop(to_stop), .timeout(to_timeout),
    .o_dbg_state(to_state));

  lt24_frame_monitor #(.WIDTH(4), .HEIGHT(2), .MAX_FRAMES(2), .MAX_CYCLES(0), .CNT_W(32)) u_nto (
    .clock(clock), .globalReset_n(globalReset_n), .LT24Wr_n(q_wr_n), .LT24CS_n(q_cs_n),
    .LT24RS(q_rs), .LT24Reset_n(q_rst_n), .LT24Data(q_data),
    .frameDone(nt_done), .frameAbort(nt_abort), .frameCount(nt_fcnt), .pixelCount(nt_pix),
    .lastChecksum(nt_last), .cycleCount(nt_cyc), .stop(nt_stop), .timeout(nt_timeout),
    .o_dbg_state(nt_state));

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected events: {kind(1=done,0=abort), frameCount, lastChecksum, cycle}
  logic [72:0] exp_q[$];

  // ---------------- reference model ----------------
  // Works on whole frames: the pixels of the open frame are kept as a list
  // and the checksum is folded over that list when the frame fills up.
  bit          m_up, m_in_frame, m_ended;
  logic [15:0] m_pix[$];
  int          m_frames;
  logic [31:0] m_last;

  function automatic logic [31:0] frame_checksum(input logic [15:0] px[$]);
    logic [31:0] c = 32'h0;
    foreach (px[i]) c = {c[30:0], c[31]} ^ {16'h0, px[i]};
    return c;
  endfunction

  task automatic push_ev(input bit kind, input logic [31:0] at);
    exp_q.push_back({kind, 8'(m_frames), m_last, at});
  endtask

  task automatic model_reset();
    m_up = 0; m_in_frame = 0; m_ended = 0; m_pix.delete(); m_frames = 0; m_last = 0;
  endtask

  task automatic model_strobe(input bit rs, input logic [15:0] d, input bit cs_n, input logic [31:0] at);
    if (m_ended || cs_n || !m_up) return;
    if (!rs) begin
      if (d == 16'h002C) begin
        if (m_in_frame && m_pix.size() != 0) push_ev(0, at);
        m_pix.delete();
        m_in_frame = 1;
      end else if (d != 16'h003C && m_in_frame) begin
        if (m_pix.size() != 0) push_ev(0, at);
        m_pix.delete();
        m_in_frame = 0;
      end
    end else if (m_in_frame) begin
      m_pix.push_back(d);
      if (m_pix.size() == NPIX) begin
        if (m_frames < 255) m_frames++;
        m_last = frame_checksum(m_pix);
        m_pix.delete();
        push_ev(1, at);
        if (m_frames == MF) m_ended = 1;
      end
    end
  endtask

  task automatic model_disp_down(input logic [31:0] at);
    if (m_ended) return;
    if (m_pix.size() != 0) push_ev(0, at);
    m_pix.delete();
    m_in_frame = 0;
    m_up = 0;
  endtask

  // ---------------- drivers ----------------
  task automatic bus_write(input bit rs, input logic [15:0] d, input bit cs_n);
    @(negedge clock);
    LT24CS_n = cs_n; LT24RS = rs; LT24Data = d; LT24Wr_n = 1'b0;
    @(negedge clock);
    LT24Wr_n = 1'b1;
    LT24Data = 16'($urandom);
    LT24RS   = 1'($urandom);
    model_strobe(rs, d, cs_n, cyc + 1);
    @(negedge clock);
    LT24CS_n = 1'b0;
  endtask

  task automatic disp_reset(input int hold);
    @(negedge clock);
    LT24Reset_n = 1'b0;
    model_disp_down(cyc + 1);
    repeat (hold) @(negedge clock);
    LT24Reset_n = 1'b1;
    if (!m_ended) m_up = 1;
    repeat (2) @(negedge clock);
  endtask

  task automatic do_reset();
    @(negedge clock);
    check("queue_drained_before_reset", exp_q.size(), 0);
    exp_q.delete();
    globalReset_n = 1'b0;
    LT24Wr_n = 1'b1; LT24CS_n = 1'b0; LT24Reset_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clock);
    globalReset_n = 1'b1;
    LT24Reset_n = 1'b1;
    m_up = 1;
    repeat (2) @(negedge clock);
  endtask

  task automatic settle();
    repeat (3) @(negedge clock);
  endtask

  task automatic check_model(input string tag);
    check({tag, "_frameCount"}, frameCount, m_frames);
    check({tag, "_pixelCount"}, pixelCount, m_pix.size());
    check({tag, "_lastChecksum"}, lastChecksum, m_last);
    check({tag, "_stop"}, stop, m_ended);
    check({tag, "_timeout"}, timeout, 0);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clock) begin
    if (globalReset_n && (frameDone || frameAbort)) begin
      if (exp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL sb_unexpected: got done=%0b abort=%0b, expected no event (t=%0t)",
                 frameDone, frameAbort, $time);
      end else begin
        logic [72:0] e;
        e = exp_q.pop_front();
        check("sb_done",       frameDone,    e[72]);
        check("sb_abort",      frameAbort,   !e[72]);
        check("sb_frameCount", frameCount,   e[71:64]);
        check("sb_checksum",   lastChecksum, e[63:32]);
        check("sb_latency",    cyc,          e[31:0]);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] frozen;
    bit seen;
    model_reset();

    // Reset state
    repeat (2) @(negedge clock);
    check("rst_outputs", {frameDone, frameAbort, stop, timeout, dbg_state}, 0);
    check("rst_counts", {7'd0, frameCount, pixelCount}, 0);
    check("rst_checksum", lastChecksum, 0);
    check("rst_cycles", cycleCount, 0);

    globalReset_n = 1'b1;
    LT24CS_n = 1'b0; LT24Reset_n = 1'b1;
    m_up = 1;
    repeat (2) @(negedge clock);

    // Frame of 1..8
    bus_write(0, 16'h002C, 0);
    for (int i = 1; i <= 8; i++) bus_write(1, 16'(i), 0);
    settle();
    check("t1_frameCount", frameCount, 1);
    check("t1_checksum_const", lastChecksum, 32'h0000_0016);
    check_model("t1");

    // Cycle limit of 50 on an idle bus, and disabled limit
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clock);
      if (to_cyc == 49) check("t4_no_early_timeout", to_timeout, 0);
      if (to_timeout) begin
        seen = 1;
        check("t4_timeout_at_50", to_cyc, 50);
      end
    end
    check("t4_timeout_seen", seen, 1);
    repeat (5) @(negedge clock);
    check("t4_cycles_frozen", to_cyc, 50);
    check("t4_no_stop", to_stop, 0);
    check("t4_disabled_no_timeout", nt_timeout, 0);
    check("t4_disabled_counting", nt_cyc > 32'd50, 1);

    // Partial frame then a foreign command
    bus_write(0, 16'h002C, 0);
    for (int i = 0; i < 3; i++) bus_write(1, 16'($urandom), 0);
    bus_write(0, 16'h002A, 0);
    settle();
    check("t2_state_wait", dbg_state, 3'd1);
    check_model("t2");
    bus_write(1, 16'h1234, 0);
    settle();
    check("t2_data_ignored", pixelCount, 0);

    // Two frames back to back then stop
    do_reset();
    bus_write(0, 16'h002C, 0);
    for (int i = 0; i < 16; i++) bus_write(1, 16'($urandom), 0);
    settle();
    check_model("t3");
    check("t3_stop", stop, 1);
    check("t3_state_done", dbg_state, 3'd3);
    bus_write(1, 16'hBEEF, 0);
    frozen = cycleCount;
    repeat (10) @(negedge clock);
    check("t3_pix_after_stop", pixelCount, 0);
    check("t3_cycles_frozen", cycleCount, frozen);

    // Display reset mid-frame, chip-select gating
    do_reset();
    bus_write(0, 16'h002C, 0);
    for (int i = 0; i < 8; i++) bus_write(1, 16'($urandom), 0);
    bus_write(0, 16'h002C, 0);
    for (int i = 0; i < 5; i++) bus_write(1, 16'($urandom), 0);
    disp_reset(2);
    settle();
    check_model("t5_after_disp_reset");
    bus_write(0, 16'h002C, 0);
    for (int i = 0; i < 2; i++) bus_write(1, 16'($urandom), 0);
    for (int i = 0; i < 3; i++) bus_write(1, 16'($urandom), 1);
    bus_write(0, 16'h002A, 1);
    settle();
    check("t6_cs_high_pix", pixelCount, 2);
    check_model("t6");
    for (int i = 0; i < 6; i++) bus_write(1, 16'($urandom), 0);
    settle();
    check_model("t5_new_frame");

    // Random traffic
    for (int r = 0; r < 4; r++) begin
      do_reset();
      for (int k = 0; k < 50; k++) begin
        int op;
        logic [15:0] c;
        op = $urandom_range(0, 15);
        case (op)
          0, 1: bus_write(0, 16'h002C, 0);
          2:    bus_write(0, 16'h003C, 0);
          3: begin
            c = 16'($urandom_range(0, 255));
            if (c == 16'h002C || c == 16'h003C) c = 16'h002A;
            bus_write(0, c, 0);
          end
          4:    bus_write(1, 16'($urandom), 1);
          5:    disp_reset($urandom_range(1, 3));
          default: bus_write(1, 16'($urandom), 0);
        endcase
      end
      settle();
      check_model("rand");
    end

    // Asynchronous reset mid-frame
    do_reset();
    bus_write(0, 16'h002C, 0);
    for (int i = 0; i < 8; i++) bus_write(1, 16'($urandom), 0);
    for (int i = 0; i < 3; i++) bus_write(1, 16'($urandom), 0);
    settle();
    check("t6_pre_reset_pix", pixelCount, 3);
    @(negedge clock);
    #2 globalReset_n = 1'b0;
    #1;
    check("t6_async_outputs", {frameDone, frameAbort, stop, timeout, dbg_state}, 0);
    check("t6_async_counts", {7'd0, frameCount, pixelCount}, 0);
    check("t6_async_checksum", lastChecksum, 0);
    check("t6_async_cycles", cycleCount, 0);
    model_reset();
    exp_q.delete();
    repeat (2) @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
